// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU port, debug port and memory side.
// The arbiter uses the slave view; the driving environment uses the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a debug/loader port.
// CPU has priority; the debug port is forced through after STARVE_LIMIT waiting
// cycles and may lock the memory for a burst. Reads return one cycle later and
// are routed back to the port that issued them.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic { ARB = 1'b0, DBG_LOCK = 1'b1 } state_e;
    typedef enum logic { OWN_CPU = 1'b0, OWN_DBG = 1'b1 } owner_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Memory is word organised: byte-offset bits never reach it.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r      = a;
        r[1:0] = 2'b00;
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        rd_pend_q, rd_pend_d;
    owner_e      rd_owner_q, rd_owner_d;

    logic        force_dbg_s;
    logic        cpu_gnt_s;
    logic        dbg_gnt_s;
    logic        cpu_rvalid_s;
    logic        dbg_rvalid_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Grant decision: lock owner first, then starvation override, then CPU priority; nothing during reset.
    always_comb begin
        force_dbg_s = (state_q == ARB) && (starve_cnt_q == STARVE_MAX);
        cpu_gnt_s   = 1'b0;
        dbg_gnt_s   = 1'b0;
        if (rst) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else begin
            cpu_gnt_s = bus.cpu_req && (state_q == ARB) && !force_dbg_s;
            dbg_gnt_s = bus.dbg_req && ((state_q == DBG_LOCK) || force_dbg_s || !bus.cpu_req);
        end
    end

    // Route the granted port onto the memory bus; idle bus is all zeros.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (cpu_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.cpu_we;
            mem_addr_s  = word_align(bus.cpu_addr);
            mem_wdata_s = bus.cpu_wdata;
        end else if (dbg_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.dbg_we;
            mem_addr_s  = word_align(bus.dbg_addr);
            mem_wdata_s = bus.dbg_wdata;
        end else begin
            mem_en_s    = 1'b0;
        end
    end

    // Next-state: read-return tag, debug starvation counter and lock state.
    always_comb begin
        rd_pend_d    = (cpu_gnt_s && !bus.cpu_we) || (dbg_gnt_s && !bus.dbg_we);
        rd_owner_d   = dbg_gnt_s ? OWN_DBG : OWN_CPU;
        starve_cnt_d = 4'd0;
        state_d      = state_q;
        if (bus.dbg_req && !dbg_gnt_s) begin
            if (starve_cnt_q < STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end else begin
                starve_cnt_d = STARVE_MAX;
            end
        end else begin
            starve_cnt_d = 4'd0;
        end
        case (state_q)
            ARB: begin
                if (dbg_gnt_s && bus.dbg_lock) begin
                    state_d = DBG_LOCK;
                end else begin
                    state_d = ARB;
                end
            end
            DBG_LOCK: begin
                if (!bus.dbg_lock) begin
                    state_d = ARB;
                end else begin
                    state_d = DBG_LOCK;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= OWN_CPU;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // A read tagged before reset must not surface during the reset cycle.
    assign cpu_rvalid_s = !rst && rd_pend_q && (rd_owner_q == OWN_CPU);
    assign dbg_rvalid_s = !rst && rd_pend_q && (rd_owner_q == OWN_DBG);

    assign bus.cpu_gnt    = cpu_gnt_s;
    assign bus.dbg_gnt    = dbg_gnt_s;
    assign bus.cpu_stall  = !rst && bus.cpu_req && !cpu_gnt_s;
    assign bus.cpu_rvalid = cpu_rvalid_s;
    assign bus.dbg_rvalid = dbg_rvalid_s;
    assign bus.cpu_rdata  = cpu_rvalid_s ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.dbg_rdata  = dbg_rvalid_s ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.mem_en     = mem_en_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle-level reference model predicts
// grants, bus contents and read returns; a negedge monitor compares them.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          cpu_gnt;
        logic          dbg_gnt;
        logic          cpu_stall;
        logic          mem_en;
        logic          mem_we;
        logic          cpu_rv;
        logic          dbg_rv;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
    } cyc_t;

    typedef struct packed {
        logic          to_dbg;
        logic [DW-1:0] data;
    } rd_t;

    cyc_t cyc_q[$];
    rd_t  rd_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [DW-1:0] dev_mem [16];
    logic [DW-1:0] ref_mem [16];

    // Reference model state: lock ownership, consecutive debug wait cycles, outstanding read.
    bit m_locked;
    int m_wait;
    bit m_pend;
    bit m_pend_dbg;

    function automatic logic [DW-1:0] mem_init(input int i);
        return DW'(32'hC0DE0000 + i * 32'h00010111);
    endfunction

    // Memory device: word array, read data one cycle after a read strobe, noise otherwise.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) dev_mem[i] <= mem_init(i);
            bus.mem_rdata <= $urandom;
        end else begin
            if (bus.mem_en && bus.mem_we) dev_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
            if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= dev_mem[bus.mem_addr[5:2]];
            else bus.mem_rdata <= $urandom;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: apply inputs, predict the outcome from the arbitration rules, queue expectations.
    task automatic drive(input bit r,
                         input bit creq, input bit cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                         input bit dreq, input bit dwe, input bit dlock,
                         input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                         output bit cg, output bit dg);
        cyc_t e;
        rd_t  rr;
        bit   frc;
        int   idx;
        @(posedge clk);
        #1;
        rst           = r;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.dbg_req   = dreq;
        bus.dbg_we    = dwe;
        bus.dbg_lock  = dlock;
        bus.dbg_addr  = daddr;
        bus.dbg_wdata = dwd;
        e  = '0;
        cg = 1'b0;
        dg = 1'b0;
        if (r) begin
            rd_q.delete();
            m_locked   = 1'b0;
            m_wait     = 0;
            m_pend     = 1'b0;
            m_pend_dbg = 1'b0;
            for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
        end else begin
            e.cpu_rv = m_pend && !m_pend_dbg;
            e.dbg_rv = m_pend && m_pend_dbg;
            frc = !m_locked && (m_wait == LIM);
            cg  = creq && !m_locked && !frc;
            dg  = dreq && (m_locked || frc || !creq);
            e.cpu_gnt   = cg;
            e.dbg_gnt   = dg;
            e.cpu_stall = creq && !cg;
            e.mem_en    = cg || dg;
            if (cg) begin
                e.mem_we = cwe; e.mem_addr = {caddr[AW-1:2], 2'b00}; e.mem_wdata = cwd;
            end else if (dg) begin
                e.mem_we = dwe; e.mem_addr = {daddr[AW-1:2], 2'b00}; e.mem_wdata = dwd;
            end
            idx = int'(e.mem_addr[5:2]);
            if (e.mem_en && !e.mem_we) begin
                rr.to_dbg = dg;
                rr.data   = ref_mem[idx];
                rd_q.push_back(rr);
            end
            if (e.mem_en && e.mem_we) ref_mem[idx] = e.mem_wdata;
            m_pend     = e.mem_en && !e.mem_we;
            m_pend_dbg = dg;
            m_wait     = (dreq && !dg) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
            m_locked   = m_locked ? dlock : (dg && dlock);
        end
        cyc_q.push_back(e);
    endtask

    // Monitor: compare every cycle's outputs, and pop a read response whenever rvalid is seen.
    always @(negedge clk) begin
        cyc_t e;
        rd_t  rr;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("cpu_gnt",    64'(bus.cpu_gnt),    64'(e.cpu_gnt));
            check("dbg_gnt",    64'(bus.dbg_gnt),    64'(e.dbg_gnt));
            check("cpu_stall",  64'(bus.cpu_stall),  64'(e.cpu_stall));
            check("mem_en",     64'(bus.mem_en),     64'(e.mem_en));
            check("mem_we",     64'(bus.mem_we),     64'(e.mem_we));
            check("mem_addr",   64'(bus.mem_addr),   64'(e.mem_addr));
            check("mem_wdata",  64'(bus.mem_wdata),  64'(e.mem_wdata));
            check("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(e.cpu_rv));
            check("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(e.dbg_rv));
            if (!bus.cpu_rvalid) check("cpu_rdata_idle", 64'(bus.cpu_rdata), 64'd0);
            if (!bus.dbg_rvalid) check("dbg_rdata_idle", 64'(bus.dbg_rdata), 64'd0);
            if (bus.cpu_rvalid || bus.dbg_rvalid) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_spurious: got rvalid with no read outstanding at %0t", $time);
                end else begin
                    rr = rd_q.pop_front();
                    check("rd_owner", 64'(bus.dbg_rvalid), 64'(rr.to_dbg));
                    check("rd_data", 64'(bus.cpu_rvalid ? bus.cpu_rdata : bus.dbg_rdata), 64'(rr.data));
                end
            end
        end
    end

    initial begin
        bit cg, dg, d_on, c_req, c_we, d_req, d_we, d_lock, c_hold, d_hold, r;
        logic [AW-1:0] c_addr, d_addr;
        logic [DW-1:0] c_wd, d_wd;
        int guard;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_lock = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

        // Reset with every request active: all outputs must stay low.
        repeat (3) drive(1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b1, 1'b1, $urandom, $urandom, cg, dg);

        // CPU load at an unaligned address, then idle for the return.
        drive(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);

        // Both ports held: debug starves until forced through.
        d_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'(4 * i), 32'h0, d_on, 1'b0, 1'b0, 32'h24, 32'h0, cg, dg);
            if (dg) d_on = 1'b0;
        end

        // Locked debug burst with the CPU waiting: write, idle gaps, final read on unlock.
        guard = 0;
        dg = 1'b0;
        while (!dg && guard < 20) begin
            drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA5555, 1'b1, 1'b1, 1'b1, 32'h30, 32'h12345678, cg, dg);
            guard++;
        end
        if (!dg) begin
            n_chk++; n_fail++;
            $display("FAIL lock_grant_timeout: no debug grant within %0d cycles", guard);
        end
        repeat (2) drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA5555, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, cg, dg);
        drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA5555, 1'b1, 1'b1, 1'b1, 32'h34, 32'h0BADF00D, cg, dg);
        drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, cg, dg);
        drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);

        // Alternating back-to-back reads from each port.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b1, 1'b0, 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);
            else drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'(4 * i + 16), 32'h0, cg, dg);
        end

        // Reset right after a granted read: the return must be dropped.
        drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, cg, dg);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, cg, dg);

        // Idle stretch.
        repeat (10) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);

        // Random traffic; a stalled requester holds its request until granted.
        c_req = 1'b0; d_req = 1'b0; c_hold = 1'b0; d_hold = 1'b0;
        c_we = 1'b0; d_we = 1'b0; d_lock = 1'b0;
        c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!c_hold) begin
                c_req  = ($urandom_range(0, 99) < 60);
                c_we   = $urandom_range(0, 1) == 1;
                c_addr = AW'($urandom_range(0, 63));
                c_wd   = $urandom;
            end
            if (!d_hold) begin
                d_req  = ($urandom_range(0, 99) < 45);
                d_we   = $urandom_range(0, 1) == 1;
                d_addr = AW'($urandom_range(0, 63));
                d_wd   = $urandom;
                d_lock = m_locked ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            end
            r = ($urandom_range(0, 149) == 0);
            drive(r, c_req, c_we, c_addr, c_wd, d_req, d_we, d_lock, d_addr, d_wd, cg, dg);
            c_hold = c_req && !cg && !r;
            d_hold = d_req && !dg && !r;
        end

        repeat (2) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);
        @(negedge clk);
        #1;
        check("queues_drained", 64'(cyc_q.size() + rd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive cycles the debug port may wait (1..15).
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk, rst.
REQ-005 SHALL have ports (name direction width meaning):
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-high reset
 cpu_req  in  1  pipeline MEM-stage access request
 cpu_we  in  1  1=store, 0=load
 cpu_addr  in  ADDR_W  CPU byte address
 cpu_wdata  in  DATA_W  CPU store data
 cpu_gnt  out  1  CPU access issued this cycle
 cpu_stall  out  1  hold pipeline (request not granted)
 cpu_rvalid  out  1  CPU load data valid
 cpu_rdata  out  DATA_W  CPU load data
 dbg_req  in  1  debug/loader access request
 dbg_we  in  1  1=write, 0=read
 dbg_lock  in  1  keep ownership after grant
 dbg_addr  in  ADDR_W  debug byte address
 dbg_wdata  in  DATA_W  debug write data
 dbg_gnt  out  1  debug access issued this cycle
 dbg_rvalid  out  1  debug read data valid
 dbg_rdata  out  DATA_W  debug read data
 mem_en  out  1  data memory access strobe
 mem_we  out  1  data memory write enable
 mem_addr  out  ADDR_W  data memory address
 mem_wdata  out  DATA_W  data memory write data
 mem_rdata  in  DATA_W  memory read data, valid cycle after a read strobe

Function
REQ-006 SHALL implement FSM states ARB and DBG_LOCK; plus starve_cnt (4 bits) and a registered read-return tag (rd_pend, rd_owner).
REQ-007 SHALL define force_dbg = (state==ARB) && (starve_cnt==STARVE_LIMIT).
REQ-008 SHALL drive cpu_gnt = cpu_req && state==ARB && !force_dbg, combinationally.
REQ-009 SHALL drive dbg_gnt = dbg_req && (state==DBG_LOCK || force_dbg || !cpu_req), combinationally; cpu_gnt and dbg_gnt never both 1.
REQ-010 SHALL drive cpu_stall = cpu_req && !cpu_gnt.
REQ-011 SHALL drive mem_en = cpu_gnt || dbg_gnt; mem_we/mem_wdata/mem_addr from the granted port; mem_addr[1:0] forced to 0; all mem_* 0 when no grant.
REQ-012 SHALL, on a granted read (we=0), set rd_pend=1 and rd_owner to the port next cycle; on granted write or no grant, rd_pend=0.
REQ-013 SHALL assert cpu_rvalid = rd_pend && rd_owner==CPU and dbg_rvalid = rd_pend && rd_owner==DBG; read latency exactly 1 cycle; back-to-back reads allowed every cycle.
REQ-014 SHALL drive cpu_rdata and dbg_rdata = mem_rdata when respective rvalid, else 0.
REQ-015 SHALL increment starve_cnt (saturating at STARVE_LIMIT) each cycle dbg_req && !dbg_gnt; clear it when dbg_gnt or !dbg_req.
REQ-016 SHALL transition ARB->DBG_LOCK when dbg_gnt && dbg_lock; DBG_LOCK->ARB on the first cycle dbg_lock==0 (grant in that cycle still follows DBG_LOCK rules).
REQ-017 SHALL, in DBG_LOCK with dbg_req==0, issue no access (mem_en=0) and stall the CPU.
REQ-018 SHALL give no grant and mem_en=0 when neither port requests; state unchanged.
REQ-019 SHALL treat requests as single-cycle: a stalled requester holds req/we/addr/wdata stable until granted.

Reset
REQ-020 SHALL on rst=1 at a clock edge set state=ARB, starve_cnt=0, rd_pend=0; a read issued the cycle before reset produces no rvalid.
REQ-021 SHALL hold all outputs at 0 during the reset cycle regardless of inputs (grants gated by rst).

Verification
REQ-022 CPU load only: cpu_req=1, we=0, addr=0x13 -> cpu_gnt=1, mem_addr=0x10, mem_en=1; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata.
REQ-023 Simultaneous requests, STARVE_LIMIT=4: both held -> CPU granted 4 cycles, dbg_gnt=1 and cpu_stall=1 on cycle 5, CPU granted cycle 6, starve_cnt=0 after dbg grant.
REQ-024 dbg_lock=1 with dbg write granted, CPU requesting -> state DBG_LOCK, cpu_stall=1 until cycle after dbg_lock=0; dbg idle cycles give mem_en=0.
REQ-025 Alternating CPU read, dbg read back-to-back -> cpu_rvalid then dbg_rvalid in consecutive cycles, never both, data routed to correct port.
REQ-026 rst=1 the cycle after a granted read -> no rvalid, all outputs 0, starve_cnt=0, state ARB.
REQ-027 No requests for 10 cycles -> mem_en=0, all grants/rvalid 0, state ARB.
